rom_port_arbiter: RTL and testbench

- Shares the SoC's single-port instruction ROM between two requesters: the core's instruction-fetch port (IF) and its data-load port (LD).
- Sits between the core and the ROM inside the SoC.
- Arbitrates round-robin, sequences the ROM's fixed read latency, and returns tagged, registered responses to the owning requester.
- Keeps at most one transaction in flight; supports killing an in-flight fetch on redirect.

---
 rtl/rom_port_arbiter_pkg.sv | 9 +
 rtl/rr_arb2.sv | 11 +
 rtl/rom_port_arbiter.sv | 106 ++++++++++
 tb/tb_rom_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// rom_port_arbiter_pkg: shared types and constants for the instruction-ROM port arbiter.
package rom_port_arbiter_pkg;
    localparam int XLEN       = 32;
    localparam int ROM_AW_DEF = 12;
    localparam int CNT_W      = 3;
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LD = 1'b1;
    typedef enum logic {IDLE, WAIT} rom_arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; on contention the requester that did not win last time is chosen.
module rr_arb2
    import rom_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] | (last_grant == REQ_LD));
    assign gnt[1] = req[1] & (~req[0] | (last_grant == REQ_IF));
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares a single-port instruction ROM between fetch and load ports,
// one transaction in flight, tagged registered responses, fetch kill on redirect.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int ROM_AW  = ROM_AW_DEF,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [XLEN-1:0]   if_req_addr,
    output logic              if_req_ready,
    input  logic              if_kill,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_rerr,
    input  logic              ld_req_valid,
    input  logic [XLEN-1:0]   ld_req_addr,
    output logic              ld_req_ready,
    output logic              ld_rvalid,
    output logic [XLEN-1:0]   ld_rdata,
    output logic              ld_rerr,
    output logic              rom_ce,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_rdata,
    output logic              busy
);
    rom_arb_state_e   state, state_d;
    logic [CNT_W-1:0] cnt;
    logic             owner, last_grant, kill_pend, oor;
    logic [1:0]       gnt;
    logic [XLEN-1:0]  win_addr;
    logic             in_range, grant, capture, kill_eff, unused_ok;

    rr_arb2 u_arb (.req({ld_req_valid, if_req_valid}), .last_grant, .gnt);

    assign win_addr  = gnt[1] ? ld_req_addr : if_req_addr;
    assign in_range  = win_addr[XLEN-1:ROM_AW+2] == '0;
    assign unused_ok = ^win_addr[1:0];
    assign grant     = (state == IDLE) && (|gnt);
    assign capture   = (state == WAIT) && (cnt == CNT_W'(ROM_LAT));
    assign kill_eff  = kill_pend | (if_kill & (owner == REQ_IF));
    assign rom_ce    = grant & in_range;
    assign rom_addr  = win_addr[ROM_AW+1:2];
    assign busy      = state == WAIT;

    always_comb begin
        state_d      = state;
        if_req_ready = 1'b0;
        ld_req_ready = 1'b0;
        if (state == IDLE) begin
            if_req_ready = gnt[0];
            ld_req_ready = gnt[1];
            state_d      = |gnt ? WAIT : IDLE;
        end else if (capture) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            owner      <= REQ_IF;
            last_grant <= REQ_LD;
            kill_pend  <= 1'b0;
            oor        <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rerr    <= 1'b0;
            if_rdata   <= '0;
            ld_rvalid  <= 1'b0;
            ld_rerr    <= 1'b0;
            ld_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            if_rerr   <= 1'b0;
            ld_rvalid <= 1'b0;
            ld_rerr   <= 1'b0;
            if (grant) begin
                owner      <= gnt[1];
                last_grant <= gnt[1];
                kill_pend  <= 1'b0;
                cnt        <= CNT_W'(1);
                oor        <= ~in_range;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (if_kill && owner == REQ_IF) kill_pend <= 1'b1;
                // A killed fetch still updates rdata; only the valid/err pulse is suppressed.
                if (capture && owner == REQ_IF) begin
                    if_rdata  <= oor ? '0 : rom_rdata;
                    if_rvalid <= ~kill_eff;
                    if_rerr   <= oor & ~kill_eff;
                end else if (capture) begin
                    ld_rdata  <= oor ? '0 : rom_rdata;
                    ld_rvalid <= 1'b1;
                    ld_rerr   <= oor;
                end
            end
        end
    end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: drives two arbiters (ROM_LAT 1 and 3) with shared directed stimulus and
// compares every cycle against a transaction-level model, plus literal expectations.
`timescale 1ns/1ps
module tb_rom_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_valid = 1'b0, ld_valid = 1'b0, if_kill = 1'b0;
    logic [31:0] if_addr = '0, ld_addr = '0;
    logic [31:0] rom [4096];
    int          n_checks = 0, n_errors = 0;

    logic        if_ready [2], ld_ready [2], if_rvalid [2], ld_rvalid [2];
    logic        if_rerr [2], ld_rerr [2], rom_ce [2], busy [2];
    logic [31:0] if_rdata [2], ld_rdata [2], rom_rdata [2];
    logic [11:0] rom_addr [2];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic vi, input logic vl, input logic last);
        if (vi && vl) return last ? 0 : 1;
        return vi ? 0 : (vl ? 1 : -1);
    endfunction

    function automatic logic in_rng(input logic [31:0] a);
        return a[31:14] == 18'd0;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return in_rng(a) ? rom[a[13:2]] : 32'd0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = g ? 3 : 1;
        logic [11:0] pa [4];
        logic [3:0]  pv = '0;
        int          cyc = 0, free_at = 0, resp_at = -1;
        logic        m_last = 1'b1, r_port = 1'b0, r_err = 1'b0, r_kill = 1'b0;
        logic [31:0] r_data = '0;
        logic [31:0] m_rd [2] = '{32'd0, 32'd0};

        rom_port_arbiter #(.ROM_AW(12), .ROM_LAT(L)) dut (
            .clk(clk), .rst(rst),
            .if_req_valid(if_valid), .if_req_addr(if_addr), .if_req_ready(if_ready[g]),
            .if_kill(if_kill), .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]), .if_rerr(if_rerr[g]),
            .ld_req_valid(ld_valid), .ld_req_addr(ld_addr), .ld_req_ready(ld_ready[g]),
            .ld_rvalid(ld_rvalid[g]), .ld_rdata(ld_rdata[g]), .ld_rerr(ld_rerr[g]),
            .rom_ce(rom_ce[g]), .rom_addr(rom_addr[g]), .rom_rdata(rom_rdata[g]), .busy(busy[g])
        );

        // ROM with fixed latency; garbage outside the valid slot exposes mistimed captures.
        always @(posedge clk) begin
            pv    <= {pv[2:0], rom_ce[g]};
            pa[0] <= rom_addr[g];
            for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
        end
        assign rom_rdata[g] = pv[L-1] ? rom[pa[L-1]] : 32'hDEAD_BEEF;

        initial forever begin
            @(posedge rst);
            free_at = 0; resp_at = -1; m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
        end

        initial begin
            int w;
            logic [31:0] a;
            forever begin
                @(posedge clk);
                if (rst) begin
                    free_at = 0; resp_at = -1; m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
                end else begin
                    if (cyc < free_at && r_port == 1'b0 && if_kill) r_kill = 1'b1;
                    if (cyc == resp_at - 1) m_rd[r_port] = r_data;
                    w = cyc >= free_at ? pick(if_valid, ld_valid, m_last) : -1;
                    if (w >= 0) begin
                        a       = w == 1 ? ld_addr : if_addr;
                        r_port  = w == 1;
                        m_last  = w == 1;
                        r_data  = exp_data(a);
                        r_err   = !in_rng(a);
                        r_kill  = 1'b0;
                        free_at = cyc + L + 1;
                        resp_at = cyc + L + 1;
                    end
                end
                cyc++;
            end
        end

        initial begin
            int w;
            logic [31:0] a;
            logic rv_if, rv_ld;
            forever begin
                @(negedge clk);
                w     = cyc >= free_at ? pick(if_valid, ld_valid, m_last) : -1;
                a     = w == 1 ? ld_addr : if_addr;
                rv_if = cyc == resp_at && r_port == 1'b0 && !r_kill;
                rv_ld = cyc == resp_at && r_port == 1'b1;
                chk($sformatf("i%0d if_ready", g), 32'(if_ready[g]), 32'(w == 0));
                chk($sformatf("i%0d ld_ready", g), 32'(ld_ready[g]), 32'(w == 1));
                chk($sformatf("i%0d rom_ce", g), 32'(rom_ce[g]), 32'(w >= 0 && in_rng(a)));
                if (w >= 0 && in_rng(a)) chk($sformatf("i%0d rom_addr", g), 32'(rom_addr[g]), 32'(a[13:2]));
                chk($sformatf("i%0d busy", g), 32'(busy[g]), 32'(cyc < free_at));
                chk($sformatf("i%0d if_rvalid", g), 32'(if_rvalid[g]), 32'(rv_if));
                chk($sformatf("i%0d if_rerr", g), 32'(if_rerr[g]), 32'(rv_if & r_err));
                chk($sformatf("i%0d if_rdata", g), if_rdata[g], m_rd[0]);
                chk($sformatf("i%0d ld_rvalid", g), 32'(ld_rvalid[g]), 32'(rv_ld));
                chk($sformatf("i%0d ld_rerr", g), 32'(ld_rerr[g]), 32'(rv_ld & r_err));
                chk($sformatf("i%0d ld_rdata", g), ld_rdata[g], m_rd[1]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic is_ld, input logic [31:0] a, input logic kill_g,
                        input logic exp_ce, input logic [11:0] exp_word, input string nm);
        tick(1);
        if_valid = !is_ld; ld_valid = is_ld; if_addr = a; ld_addr = a; if_kill = kill_g;
        @(negedge clk);
        chk({nm, " ready"}, 32'(is_ld ? ld_ready[0] : if_ready[0]), 32'd1);
        chk({nm, " rom_ce"}, 32'(rom_ce[0]), 32'(exp_ce));
        if (exp_ce) chk({nm, " rom_addr"}, 32'(rom_addr[0]), 32'(exp_word));
        tick(1);
        if_valid = 1'b0; ld_valid = 1'b0; if_kill = 1'b0;
        @(negedge clk);
        chk({nm, " no early rvalid"}, 32'(is_ld ? ld_rvalid[0] : if_rvalid[0]), 32'd0);
        @(negedge clk);
        chk({nm, " rvalid"}, 32'(is_ld ? ld_rvalid[0] : if_rvalid[0]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        rom[4] = 32'h0000_0297;
        tick(2);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 32'(busy[0]), 32'd0);
        chk("reset if_rdata", if_rdata[1], 32'd0);

        xact(1'b0, 32'h0000_0010, 1'b0, 1'b1, 12'd4, "t1 fetch");
        chk("t1 if_rdata", if_rdata[0], 32'h0000_0297);
        chk("t1 if_rerr", 32'(if_rerr[0]), 32'd0);
        chk("t1 ld_rvalid", 32'(ld_rvalid[0]), 32'd0);
        repeat (2) @(negedge clk);
        chk("t1 lat3 if_rvalid", 32'(if_rvalid[1]), 32'd1);
        chk("t1 lat3 if_rdata", if_rdata[1], 32'h0000_0297);
        tick(2);

        xact(1'b0, 32'h0000_0013, 1'b1, 1'b1, 12'd4, "t2 misaligned kill-at-grant");
        chk("t2 if_rdata", if_rdata[0], 32'h0000_0297);
        tick(3);

        xact(1'b1, 32'h0000_0084, 1'b0, 1'b1, 12'd33, "t3 load");
        chk("t3 ld_rdata", ld_rdata[0], rom[33]);
        chk("t3 ld_rerr", 32'(ld_rerr[0]), 32'd0);
        tick(3);

        xact(1'b1, 32'h0001_0000, 1'b0, 1'b0, 12'd0, "t4 oor");
        chk("t4 ld_rerr", 32'(ld_rerr[0]), 32'd1);
        chk("t4 ld_rdata", ld_rdata[0], 32'd0);
        tick(3);

        tick(1);
        if_valid = 1'b1; ld_valid = 1'b1; if_addr = 32'h40; ld_addr = 32'h88;
        @(negedge clk);
        chk("t5 first if", 32'(if_ready[0]), 32'd1);
        chk("t5 first not ld", 32'(ld_ready[0]), 32'd0);
        chk("t5 lat3 first if", 32'(if_ready[1]), 32'd1);
        @(negedge clk);
        chk("t5 no grant while busy", 32'(ld_ready[0]), 32'd0);
        @(negedge clk);
        chk("t5 second ld", 32'(ld_ready[0]), 32'd1);
        repeat (2) @(negedge clk);
        chk("t5 third if", 32'(if_ready[0]), 32'd1);
        chk("t5 lat3 second ld", 32'(ld_ready[1]), 32'd1);
        tick(16);
        if_valid = 1'b0; ld_valid = 1'b0;
        tick(5);

        if_valid = 1'b1; if_addr = 32'h20;
        @(negedge clk);
        chk("t6 if grant", 32'(if_ready[0]), 32'd1);
        tick(1);
        if_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h30; if_kill = 1'b1;
        @(negedge clk);
        chk("t6 ld blocked", 32'(ld_ready[0]), 32'd0);
        tick(1);
        if_kill = 1'b0;
        @(negedge clk);
        chk("t6 killed no rvalid", 32'(if_rvalid[0]), 32'd0);
        chk("t6 ld granted", 32'(ld_ready[0]), 32'd1);
        tick(1);
        ld_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6 ld rvalid", 32'(ld_rvalid[0]), 32'd1);
        chk("t6 ld rdata", ld_rdata[0], rom[12]);
        chk("t6 lat3 killed", 32'(if_rvalid[1]), 32'd0);
        tick(3);

        if_valid = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        tick(1);
        if_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t7 pulse before rst", 32'(if_rvalid[0]), 32'd1);
        chk("t7 lat3 busy before rst", 32'(busy[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t7 rvalid dropped", 32'(if_rvalid[0]), 32'd0);
        chk("t7 busy dropped", 32'(busy[1]), 32'd0);
        chk("t7 if_rdata cleared", if_rdata[0], 32'd0);
        tick(2);
        #2 rst = 1'b0;
        tick(4);
        if_valid = 1'b1; ld_valid = 1'b1; if_addr = 32'h8; ld_addr = 32'hC;
        @(negedge clk);
        chk("t8 if first after rst", 32'(if_ready[0]), 32'd1);
        chk("t8 lat3 if first", 32'(if_ready[1]), 32'd1);
        chk("t8 ld loses", 32'(ld_ready[1]), 32'd0);
        tick(1);
        if_valid = 1'b0; ld_valid = 1'b0;
        tick(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
